// File: rtl/multimode_ff_bank_pkg.sv
// ----------------------------------------------------------------------------
// ff_pkg
// Shared definitions for the multimode flip-flop library.
//   ff_mode_t  : run-time flip-flop personality (JK / D / T / SR)
//   ff_next_t  : next-state bit plus illegal-input flag
//   ff_next()  : single-bit next-state rule, reusable by counters and FSMs
// ----------------------------------------------------------------------------
package ff_pkg;

    typedef enum logic [1:0] {
        FF_JK = 2'b00,
        FF_D  = 2'b01,
        FF_T  = 2'b10,
        FF_SR = 2'b11
    } ff_mode_t;

    typedef struct packed {
        logic nxt;
        logic illegal;
    } ff_next_t;

    // Next value of one flip-flop for the selected mode. An unknown or
    // unrecognised mode falls through to hold.
    function automatic ff_next_t ff_next(input ff_mode_t mode, input logic q,
                                         input logic a, input logic b);
        ff_next_t r;
        r.nxt     = q;
        r.illegal = 1'b0;
        case (mode)
            FF_JK: begin
                case ({a, b})
                    2'b10:   r.nxt = 1'b1;
                    2'b01:   r.nxt = 1'b0;
                    2'b11:   r.nxt = ~q;
                    default: r.nxt = q;
                endcase
            end
            FF_D: begin
                r.nxt = a;
            end
            FF_T: begin
                r.nxt = q ^ a;
            end
            FF_SR: begin
                case ({a, b})
                    2'b10:   r.nxt = 1'b1;
                    2'b01:   r.nxt = 1'b0;
                    2'b11: begin
                        // S=R=1 is forbidden: keep the state, report it
                        r.nxt     = q;
                        r.illegal = 1'b1;
                    end
                    default: r.nxt = q;
                endcase
            end
            default: begin
                r.nxt     = q;
                r.illegal = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multimode_ff_bank_if.sv
// ----------------------------------------------------------------------------
// multimode_ff_bank_if
// Control/data bundle of the multimode flip-flop bank.
//   master : drives mode, en, a, b, set_mask, clr_mask, err_clr;
//            observes q, q_bar, changed, err
//   slave  : the bank itself (directions mirrored)
// ----------------------------------------------------------------------------
interface multimode_ff_bank_if #(
    parameter int WIDTH = 8
);
    import ff_pkg::*;

    ff_mode_t           mode;
    logic [WIDTH-1:0]   en;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   set_mask;
    logic [WIDTH-1:0]   clr_mask;
    logic               err_clr;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_bar;
    logic [WIDTH-1:0]   changed;
    logic [WIDTH-1:0]   err;

    modport master (
        output mode, en, a, b, set_mask, clr_mask, err_clr,
        input  q, q_bar, changed, err
    );

    modport slave (
        input  mode, en, a, b, set_mask, clr_mask, err_clr,
        output q, q_bar, changed, err
    );

endinterface

// File: rtl/multimode_ff_bank_chk.sv
// ----------------------------------------------------------------------------
// multimode_ff_bank_chk
// Simulation-only checks on the bank inputs.
//   clk, rst_n : clock and reset of the bank
//   i_mode     : mode input of the bank
//   i_en       : per-bit enables of the bank
// ----------------------------------------------------------------------------
module multimode_ff_bank_chk #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic [1:0]       i_mode,
    input logic [WIDTH-1:0] i_en
);

    // An enabled bit with an unknown mode has no defined next state
    a_mode_known: assert property (@(posedge clk) disable iff (!rst_n)
        (|i_en) |-> !$isunknown(i_mode));

endmodule

// File: rtl/multimode_ff_bit.sv
// ----------------------------------------------------------------------------
// multimode_ff_bit
// One storage cell of the bank: state, change pulse and sticky SR error.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_mode                : shared mode (JK/D/T/SR)
//   i_en, i_a, i_b        : enable and operands for this bit
//   i_set, i_clr          : synchronous force-to-1 / force-to-0 (clr wins)
//   i_err_clr             : synchronous clear of the error flag
//   o_q, o_changed, o_err : registered state, change pulse, error flag
// ----------------------------------------------------------------------------
module multimode_ff_bit
    import ff_pkg::*;
#(
    parameter logic RESET_BIT  = 1'b0,
    parameter bit   ERR_ENABLE = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  ff_mode_t i_mode,
    input  logic     i_en,
    input  logic     i_a,
    input  logic     i_b,
    input  logic     i_set,
    input  logic     i_clr,
    input  logic     i_err_clr,
    output logic     o_q,
    output logic     o_changed,
    output logic     o_err
);

    logic     r_q;
    logic     r_changed;
    logic     r_err;
    ff_next_t w_rule;
    logic     w_q_next;
    logic     w_illegal;

    // Next state: clear beats set, set beats enable, enable selects the mode rule
    always_comb begin
        w_rule    = ff_next(i_mode, r_q, i_a, i_b);
        w_q_next  = r_q;
        w_illegal = 1'b0;
        if (i_clr) begin
            w_q_next = 1'b0;
        end else if (i_set) begin
            w_q_next = 1'b1;
        end else if (i_en) begin
            w_q_next  = w_rule.nxt;
            w_illegal = w_rule.illegal;
        end else begin
            w_q_next = r_q;
        end
    end

    // State, change pulse and sticky error; a fresh error outranks err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= RESET_BIT;
            r_changed <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_q_next ^ r_q;
            r_err     <= ERR_ENABLE ? (w_illegal | (r_err & ~i_err_clr)) : 1'b0;
        end
    end

    assign o_q       = r_q;
    assign o_changed = r_changed;
    assign o_err     = r_err;

endmodule

// File: rtl/multimode_ff_bank.sv
// ----------------------------------------------------------------------------
// multimode_ff_bank
// WIDTH flip-flops sharing one run-time mode (JK / D / T / SR), with per-bit
// enables, synchronous set/clear masks, change pulses and sticky SR errors.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q <= RESET_VAL, changed/err <= 0)
//   bus   : slave side of multimode_ff_bank_if (inputs mode/en/a/b/masks/
//           err_clr, outputs q/q_bar/changed/err)
// ----------------------------------------------------------------------------
module multimode_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter bit               ERR_ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multimode_ff_bank_if.slave   bus
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_changed;
    logic [WIDTH-1:0] w_err;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        multimode_ff_bit #(
            .RESET_BIT  (RESET_VAL[gi]),
            .ERR_ENABLE (ERR_ENABLE)
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_mode    (bus.mode),
            .i_en      (bus.en[gi]),
            .i_a       (bus.a[gi]),
            .i_b       (bus.b[gi]),
            .i_set     (bus.set_mask[gi]),
            .i_clr     (bus.clr_mask[gi]),
            .i_err_clr (bus.err_clr),
            .o_q       (w_q[gi]),
            .o_changed (w_changed[gi]),
            .o_err     (w_err[gi])
        );
    end

    multimode_ff_bank_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_mode (bus.mode),
        .i_en   (bus.en)
    );

    assign bus.q       = w_q;
    assign bus.q_bar   = ~w_q;
    assign bus.changed = w_changed;
    assign bus.err     = w_err;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// ----------------------------------------------------------------------------
// tb_multimode_ff_bank
// Directed and randomized checks of multimode_ff_bank against a reference
// model built from the flip-flop characteristic equations.
// ----------------------------------------------------------------------------
module tb_multimode_ff_bank;
    import ff_pkg::*;

    localparam logic [7:0] RV8 = 8'hA5;
    localparam logic       RV1 = 1'b1;

    logic clk;
    logic clk_run;
    logic rst_n;
    logic rst_n1;

    int n_pass;
    int n_total;

    logic [7:0] m_q;
    logic [7:0] m_chg;
    logic [7:0] m_err;

    multimode_ff_bank_if #(.WIDTH(8)) bus  ();
    multimode_ff_bank_if #(.WIDTH(1)) bus1 ();

    multimode_ff_bank #(.WIDTH(8), .RESET_VAL(RV8), .ERR_ENABLE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multimode_ff_bank #(.WIDTH(1), .RESET_VAL(RV1), .ERR_ENABLE(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1)
    );

    // Stoppable clock
    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q   = RV8;
        m_chg = 8'h00;
        m_err = 8'h00;
    endtask

    // Characteristic equations of each flip-flop kind
    task automatic model_step();
        logic [7:0] f;
        logic [7:0] ill;
        logic [7:0] nq;
        ill = 8'h00;
        case (bus.mode)
            FF_JK:   f = (bus.a & ~m_q) | (~bus.b & m_q);
            FF_D:    f = bus.a;
            FF_T:    f = m_q ^ bus.a;
            default: begin
                ill = bus.a & bus.b;
                f   = ((bus.a | (~bus.b & m_q)) & ~ill) | (m_q & ill);
            end
        endcase
        nq    = ((bus.en & f) | (~bus.en & m_q) | bus.set_mask) & ~bus.clr_mask;
        ill   = ill & bus.en & ~bus.set_mask & ~bus.clr_mask;
        m_err = ill | (m_err & ~{8{bus.err_clr}});
        m_chg = nq ^ m_q;
        m_q   = nq;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".q"},       {56'd0, bus.q},       {56'd0, m_q});
        chk({tag, ".q_bar"},   {56'd0, bus.q_bar},   {56'd0, ~m_q});
        chk({tag, ".changed"}, {56'd0, bus.changed}, {56'd0, m_chg});
        chk({tag, ".err"},     {56'd0, bus.err},     {56'd0, m_err});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic drive(input ff_mode_t md, input logic [7:0] e, input logic [7:0] va,
                         input logic [7:0] vb, input logic [7:0] sm, input logic [7:0] cm,
                         input logic ec);
        bus.mode     = md;
        bus.en       = e;
        bus.a        = va;
        bus.b        = vb;
        bus.set_mask = sm;
        bus.clr_mask = cm;
        bus.err_clr  = ec;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clk     = 1'b0;
        clk_run = 1'b1;
        rst_n   = 1'b0;
        rst_n1  = 1'b0;
        drive(FF_D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        bus1.mode = FF_T; bus1.en = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
        bus1.set_mask = 1'b0; bus1.clr_mask = 1'b0; bus1.err_clr = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst.q",       {56'd0, bus.q},       64'hA5);
        chk("rst.changed", {56'd0, bus.changed}, 64'h00);
        chk("rst.err",     {56'd0, bus.err},     64'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Move away from reset value, then reset with the clock stopped
        drive(FF_D, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick("d00");
        chk("d00.const", {56'd0, bus.q}, 64'h00);
        clk_run = 1'b0;
        #20;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async.q",       {56'd0, bus.q},       64'hA5);
        chk("async.changed", {56'd0, bus.changed}, 64'h00);
        chk("async.err",     {56'd0, bus.err},     64'h00);
        #5;
        rst_n = 1'b1;
        #3;
        clk_run = 1'b1;

        // JK truth table from q = 0F
        drive(FF_D, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b0);
        tick("d0f");
        drive(FF_JK, 8'hFF, 8'hCC, 8'hAA, 8'h00, 8'h00, 1'b0);
        tick("jk");
        chk("jk.q",       {56'd0, bus.q},       64'hC5);
        chk("jk.changed", {56'd0, bus.changed}, 64'hCA);

        // D then T twice, then disabled
        drive(FF_D, 8'hFF, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0);
        tick("d3c");
        chk("d3c.q", {56'd0, bus.q}, 64'h3C);
        drive(FF_T, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        tick("t1");
        chk("t1.q",       {56'd0, bus.q},       64'hC3);
        chk("t1.changed", {56'd0, bus.changed}, 64'hFF);
        tick("t2");
        chk("t2.q",       {56'd0, bus.q},       64'h3C);
        chk("t2.changed", {56'd0, bus.changed}, 64'hFF);
        drive(FF_T, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        tick("hold");
        chk("hold.q",       {56'd0, bus.q},       64'h3C);
        chk("hold.changed", {56'd0, bus.changed}, 64'h00);

        // Mask priority: clear > set > D
        drive(FF_D, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick("d00b");
        drive(FF_D, 8'hFF, 8'hFF, 8'h00, 8'hF0, 8'h30, 1'b0);
        tick("mask");
        chk("mask.q", {56'd0, bus.q}, 64'hCF);
        // Forcing a bit to its current value is not a change
        drive(FF_D, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h30, 1'b0);
        tick("mask2");
        chk("mask2.changed", {56'd0, bus.changed}, 64'h00);

        // SR illegal input and sticky err
        drive(FF_D, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        tick("d01");
        drive(FF_SR, 8'hFF, 8'h81, 8'h81, 8'h00, 8'h00, 1'b0);
        tick("sr_ill");
        chk("sr_ill.q",   {56'd0, bus.q},   64'h01);
        chk("sr_ill.err", {56'd0, bus.err}, 64'h81);
        drive(FF_SR, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 1'b1);
        tick("sr_setwins");
        chk("sr_setwins.err", {56'd0, bus.err}, 64'h01);
        drive(FF_SR, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        tick("sr_clr");
        chk("sr_clr.err", {56'd0, bus.err}, 64'h00);
        // Masked and disabled bits never flag
        drive(FF_SR, 8'h0F, 8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
        tick("sr_mask");
        chk("sr_mask.err", {56'd0, bus.err}, 64'h0C);

        // Randomized traffic with one mid-cycle asynchronous reset
        for (int i = 0; i < 300; i++) begin
            drive(ff_mode_t'(2'($urandom_range(0, 3))), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom & $urandom & $urandom),
                  8'($urandom & $urandom & $urandom), ($urandom_range(0, 7) == 0));
            tick("rnd");
            if (i == 150) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_model("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // WIDTH = 1 bank in T mode; reset lands on an edge
        @(negedge clk);
        rst_n1 = 1'b1;
        bus1.en = 1'b1;
        bus1.a  = 1'b1;
        @(posedge clk); #1;
        chk("w1.t1.q",       {63'd0, bus1.q},       64'h0);
        chk("w1.t1.changed", {63'd0, bus1.changed}, 64'h1);
        @(posedge clk); #1;
        chk("w1.t2.q", {63'd0, bus1.q}, 64'h1);
        @(posedge clk);
        rst_n1 = 1'b0;
        #1;
        chk("w1.rst.q",       {63'd0, bus1.q},       64'h1);
        chk("w1.rst.q_bar",   {63'd0, bus1.q_bar},   64'h0);
        chk("w1.rst.changed", {63'd0, bus1.changed}, 64'h0);
        @(posedge clk); #1;
        chk("w1.held.q", {63'd0, bus1.q}, 64'h1);
        @(negedge clk);
        rst_n1 = 1'b1;
        @(posedge clk); #1;
        chk("w1.rel.q",       {63'd0, bus1.q},       64'h0);
        chk("w1.rel.changed", {63'd0, bus1.changed}, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
